// File: rtl/az_sequencer.sv
// Auto-zero run controller: sequences the precharge switch and AZ mux through HI/LO sample cycles.
// Optional build macro AZ_SEQ_LO_ALT_EN: alternate the LO mux code between lo_sel_a/lo_sel_b per cycle.
module az_sequencer #(
  parameter int         CNT_W      = 24,
  parameter int         IDX_W      = 16,
  parameter logic [3:0] MUX_PC_OUT = 4'b1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] nplc_clks,
  input  logic [CNT_W-1:0] pc_clks,
  input  logic [IDX_W-1:0] cycles_n,
  input  logic [3:0]       lo_sel_a,
  input  logic [3:0]       lo_sel_b,
  output logic             sw_pc_ctl,
  output logic [3:0]       azmux,
  output logic             sample_hi,
  output logic             sample_lo,
  output logic [IDX_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       monitor
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BOOT      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_SAMPLE_HI = 3'd3,
    ST_PROTECT   = 3'd4,
    ST_SAMPLE_LO = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_pc_len;
  logic [CNT_W-1:0] r_nplc_len;
  logic [IDX_W-1:0] r_cycles;
  logic [3:0]       r_lo_a;
  logic             r_pc;
  logic [3:0]       r_azmux;
  logic             r_sample_hi;
  logic             r_sample_lo;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_monitor;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_accept;
  logic             w_hi_stb;
  logic             w_lo_stb;
  logic             w_done;
  logic [3:0]       w_lo_a;
  logic [3:0]       w_lo_code;
  logic [3:0]       w_az_next;
  logic             w_pc_next;
  logic             w_busy_next;

  // The counter holds remaining clks minus one, so a zero length still yields one clk.
  function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_idx_inc    = r_idx + IDX_W'(1);
    w_accept     = 1'b0;
    w_hi_stb     = 1'b0;
    w_lo_stb     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_accept     = 1'b1;
          w_state_next = ST_BOOT;
          w_cnt_next   = f_load(pc_clks);
          w_idx_next   = '0;
        end
      end
      default: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
          case (r_state)
            ST_BOOT: begin
              w_state_next = ST_SETTLE;
              w_cnt_next   = f_load(r_pc_len);
            end
            ST_SETTLE: begin
              w_state_next = ST_SAMPLE_HI;
              w_cnt_next   = f_load(r_nplc_len);
            end
            ST_SAMPLE_HI: begin
              w_state_next = ST_PROTECT;
              w_cnt_next   = f_load(r_pc_len);
              w_hi_stb     = 1'b1;
            end
            ST_PROTECT: begin
              w_state_next = ST_SAMPLE_LO;
              w_cnt_next   = f_load(r_nplc_len);
            end
            ST_SAMPLE_LO: begin
              w_lo_stb   = 1'b1;
              w_idx_next = w_idx_inc;
              if ((r_cycles != '0) && (w_idx_inc == r_cycles)) begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_done       = 1'b1;
              end else begin
                w_state_next = ST_SETTLE;
                w_cnt_next   = f_load(r_pc_len);
              end
            end
            default: begin
              w_state_next = ST_IDLE;
              w_cnt_next   = '0;
            end
          endcase
        end
      end
    endcase
  end

  assign w_lo_a = w_accept ? lo_sel_a : r_lo_a;

`ifdef AZ_SEQ_LO_ALT_EN
  logic [3:0] r_lo_b;
  // The index is stable for the whole LO phase, so its parity picks the code.
  assign w_lo_code = ((w_state_next == ST_SAMPLE_LO) && w_idx_next[0]) ? r_lo_b : w_lo_a;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo_b <= '0;
    end else if (w_accept) begin
      r_lo_b <= lo_sel_b;
    end
  end
`else
  logic w_unused_lo_b;
  assign w_unused_lo_b = ^lo_sel_b;
  assign w_lo_code     = w_lo_a;
`endif

  always_comb begin
    w_az_next = 4'b0000;
    case (w_state_next)
      ST_BOOT, ST_SAMPLE_LO:                w_az_next = w_lo_code;
      ST_SETTLE, ST_SAMPLE_HI, ST_PROTECT:  w_az_next = MUX_PC_OUT;
      default:                              w_az_next = 4'b0000;
    endcase
  end

  assign w_pc_next   = (w_state_next == ST_SAMPLE_HI);
  assign w_busy_next = (w_state_next != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pc_len    <= '0;
      r_nplc_len  <= '0;
      r_cycles    <= '0;
      r_lo_a      <= '0;
      r_pc        <= 1'b0;
      r_azmux     <= 4'b0000;
      r_sample_hi <= 1'b0;
      r_sample_lo <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_monitor   <= 8'h00;
    end else begin
      if (w_accept) begin
        r_pc_len   <= pc_clks;
        r_nplc_len <= nplc_clks;
        r_cycles   <= cycles_n;
        r_lo_a     <= lo_sel_a;
      end
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_pc        <= w_pc_next;
      r_azmux     <= w_az_next;
      r_sample_hi <= w_hi_stb;
      r_sample_lo <= w_lo_stb;
      r_busy      <= w_busy_next;
      r_done      <= w_done;
      r_monitor   <= {w_busy_next, w_state_next, w_lo_stb, w_hi_stb, w_pc_next,
                      (w_az_next == MUX_PC_OUT)};
    end
  end

  assign sw_pc_ctl  = r_pc;
  assign azmux      = r_azmux;
  assign sample_hi  = r_sample_hi;
  assign sample_lo  = r_sample_lo;
  assign sample_idx = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign monitor    = r_monitor;

endmodule
